// File: rtl/pipe_alu_mem_fwd.sv
// pipe_alu_mem_fwd: four-stage register fetch / ALU / regbank writeback / memory store pipeline with full operand forwarding.
// Latency: zout is valid 2 enabled edges after the capture edge; memory is written on the enabled edge after that.
// Backpressure: none; en=0 freezes every stage, blocks all writes and ignores in_valid.
//
// Ports:
//   clk, rst_n              single clock, asynchronous active-low reset
//   en                      advance enable (0 = global stall)
//   in_valid, rs1, rs2, rd  instruction: valid tag, source/destination register indices
//   func, addr              operation code (12..15 illegal), memory store address
//   zout, zout_valid        writeback-stage result and its valid flag
//   err_illegal             one-cycle pulse when an illegal op enters the ALU result stage
//   mem_rd_addr/mem_rd_data asynchronous observation read of the data memory
module pipe_alu_mem_fwd #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int RW   = $clog2(NREG),
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_valid,
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic [RW-1:0] rd,
    input  logic [3:0]    func,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] zout,
    output logic          zout_valid,
    output logic          err_illegal,
    input  logic [AW-1:0] mem_rd_addr,
    output logic [DW-1:0] mem_rd_data
);

    // Stage 1: captured instruction with resolved operands
    logic          r_s1_vld;
    logic [RW-1:0] r_s1_rd;
    logic [3:0]    r_s1_func;
    logic [AW-1:0] r_s1_addr;
    logic [DW-1:0] r_s1_a;
    logic [DW-1:0] r_s1_b;

    // Stage 2: ALU result (valid already cleared for illegal ops)
    logic          r_s2_vld;
    logic [RW-1:0] r_s2_rd;
    logic [AW-1:0] r_s2_addr;
    logic [DW-1:0] r_s2_z;

    // Stage 3: writeback result; r_zout doubles as the store data for stage 4
    logic          r_s3_vld;
    logic [AW-1:0] r_s3_addr;
    logic [DW-1:0] r_zout;
    logic          r_err;

    logic [DW-1:0] r_regbank [NREG];
    logic [DW-1:0] r_mem [2**AW];

    logic          w_s1_legal;
    logic [DW-1:0] w_alu_z;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;

    assign w_s1_legal = (r_s1_func < 4'd12);

    always_comb begin
        w_alu_z = '0;
        case (r_s1_func)
            4'd0:    w_alu_z = r_s1_a + r_s1_b;
            4'd1:    w_alu_z = r_s1_a - r_s1_b;
            4'd2:    w_alu_z = r_s1_a * r_s1_b;
            4'd3:    w_alu_z = r_s1_a;
            4'd4:    w_alu_z = r_s1_b;
            4'd5:    w_alu_z = r_s1_a & r_s1_b;
            4'd6:    w_alu_z = r_s1_a | r_s1_b;
            4'd7:    w_alu_z = r_s1_a ^ r_s1_b;
            4'd8:    w_alu_z = -r_s1_a;
            4'd9:    w_alu_z = -r_s1_b;
            4'd10:   w_alu_z = r_s1_a >> 1;
            4'd11:   w_alu_z = r_s1_a << 1;
            default: w_alu_z = '0;
        endcase
    end

    // Operand resolution at capture: the instruction now in S1 is newest, then S2.
    // Anything older has already landed in the regbank by this edge, so two
    // levels of bypass cover every RAW hazard. An illegal op in S1 is skipped
    // so the dependant sees the last legal producer.
    always_comb begin
        w_op_a = r_regbank[rs1];
        if (r_s1_vld && w_s1_legal && (r_s1_rd == rs1)) begin
            w_op_a = w_alu_z;
        end else if (r_s2_vld && (r_s2_rd == rs1)) begin
            w_op_a = r_s2_z;
        end
    end

    always_comb begin
        w_op_b = r_regbank[rs2];
        if (r_s1_vld && w_s1_legal && (r_s1_rd == rs2)) begin
            w_op_b = w_alu_z;
        end else if (r_s2_vld && (r_s2_rd == rs2)) begin
            w_op_b = r_s2_z;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_rd   <= '0;
            r_s1_func <= '0;
            r_s1_addr <= '0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_rd   <= '0;
            r_s2_addr <= '0;
            r_s2_z    <= '0;
            r_s3_vld  <= 1'b0;
            r_s3_addr <= '0;
            r_zout    <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regbank[i] <= '0;
            end
        end else if (en) begin
            r_s1_vld  <= in_valid;
            r_s1_rd   <= rd;
            r_s1_func <= func;
            r_s1_addr <= addr;
            r_s1_a    <= w_op_a;
            r_s1_b    <= w_op_b;

            // Illegal ops are squashed here so no later stage ever writes.
            r_s2_vld  <= r_s1_vld && w_s1_legal;
            r_s2_rd   <= r_s1_rd;
            r_s2_addr <= r_s1_addr;
            r_s2_z    <= w_alu_z;
            r_err     <= r_s1_vld && !w_s1_legal;

            r_s3_vld  <= r_s2_vld;
            if (r_s2_vld) begin
                r_zout               <= r_s2_z;
                r_s3_addr            <= r_s2_addr;
                r_regbank[r_s2_rd]   <= r_s2_z;
            end
        end else begin
            r_err <= 1'b0;
        end
    end

    // Data memory is not reset; a flushed store cannot fire because reset
    // clears r_s3_vld asynchronously.
    always_ff @(posedge clk) begin
        if (en && r_s3_vld) begin
            r_mem[r_s3_addr] <= r_zout;
        end
    end

    assign mem_rd_data = r_mem[mem_rd_addr];
    assign zout        = r_zout;
    assign zout_valid  = r_s3_vld;
    assign err_illegal = r_err;

endmodule

// File: tb/tb_pipe_alu_mem_fwd.sv
// tb_pipe_alu_mem_fwd: directed self-checking bench for pipe_alu_mem_fwd.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge after each rising edge.
// Backpressure: exercised through en stalls; the ISA has no immediates, so seed registers are deposited hierarchically.
module tb_pipe_alu_mem_fwd;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [15:0] zout;
    logic        zout_valid;
    logic        err_illegal;
    logic [7:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    pipe_alu_mem_fwd dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_valid    (in_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func        (func),
        .addr        (addr),
        .zout        (zout),
        .zout_valid  (zout_valid),
        .err_illegal (err_illegal),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic [3:0] f, input logic [7:0] ad);
        in_valid = v; rs1 = a; rs2 = b; rd = d; func = f; addr = ad;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; in_valid = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0; mem_rd_addr = '0;
        @(negedge clk);
        dut.r_regbank[7] <= 16'h1234;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (zout !== 16'h0) begin errors++; $display("FAIL reset_zout got %h exp 0000", zout); end
        checks++; if (zout_valid !== 1'b0) begin errors++; $display("FAIL reset_zv got %b exp 0", zout_valid); end
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_illegal); end
        step(); step();
        rst_n = 1'b1; en = 1'b1;
        issue(1'b1, 4'd7, 4'd0, 4'd15, 4'd3, 8'hF0);
        issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
        checks++; if (zout_valid !== 1'b0) begin errors++; $display("FAIL reset_early_zv got %b exp 0", zout_valid); end
        issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
        checks++; if (zout_valid !== 1'b1) begin errors++; $display("FAIL reset_read_zv got %b exp 1", zout_valid); end
        checks++; if (zout !== 16'h0000) begin errors++; $display("FAIL reset_read_r7 got %h exp 0000", zout); end
        issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
        checks++; if (zout_valid !== 1'b0) begin errors++; $display("FAIL reset_bubble_zv got %b exp 0", zout_valid); end
    endtask

    task automatic test_fwd_chain();
        logic [3:0]  f [5] = '{4'd3, 4'd4, 4'd0, 4'd2, 4'd1};
        logic [3:0]  a [5] = '{4'd10, 4'd0, 4'd1, 4'd3, 4'd4};
        logic [3:0]  b [5] = '{4'd0, 4'd11, 4'd2, 4'd3, 4'd1};
        logic [3:0]  d [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        logic [7:0]  ad[5] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22};
        logic [15:0] ex[5] = '{16'd5, 16'd3, 16'd8, 16'd64, 16'd59};
        dut.r_regbank[10] <= 16'd5;
        dut.r_regbank[11] <= 16'd3;
        for (int s = 0; s < 8; s++) begin
            if (s < 5) issue(1'b1, a[s], b[s], d[s], f[s], ad[s]);
            else       issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
            if (s >= 2 && s < 7) begin
                checks++; if (zout_valid !== 1'b1 || zout !== ex[s-2]) begin errors++;
                    $display("FAIL fwd_zout[%0d] got %b/%0d exp 1/%0d", s-2, zout_valid, zout, ex[s-2]); end
            end
            if (s >= 3) begin
                mem_rd_addr = ad[s-3]; #1;
                checks++; if (mem_rd_data !== ex[s-3]) begin errors++;
                    $display("FAIL fwd_mem[%0d] got %0d exp %0d", s-3, mem_rd_data, ex[s-3]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] ez[4] = '{16'd56, 16'd5, 16'd61, 16'd61};
        logic        ev[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] em[4] = '{16'd51, 16'd56, 16'd5, 16'd61};
        issue(1'b1, 4'd5, 4'd3, 4'd6, 4'd7, 8'h20);
        issue(1'b1, 4'd6, 4'd1, 4'd7, 4'd0, 8'h21);
        issue(1'b1, 4'd7, 4'd6, 4'd8, 4'd1, 8'h22);
        checks++; if (zout !== 16'd51) begin errors++; $display("FAIL stall_pre_zout got %0d exp 51", zout); end
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            issue(1'b1, 4'd1, 4'd1, 4'd9, 4'd0, 8'h30);
            mem_rd_addr = 8'h20; #1;
            checks++; if (zout !== 16'd51 || zout_valid !== 1'b1 || err_illegal !== 1'b0) begin errors++;
                $display("FAIL stall_hold[%0d] got %0d/%b/%b exp 51/1/0", s, zout, zout_valid, err_illegal); end
            checks++; if (mem_rd_data !== 16'd8) begin errors++;
                $display("FAIL stall_mem[%0d] got %0d exp 8", s, mem_rd_data); end
        end
        en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if (s == 0) issue(1'b1, 4'd8, 4'd7, 4'd9, 4'd0, 8'h23);
            else        issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
            checks++; if (zout_valid !== ev[s] || zout !== ez[s]) begin errors++;
                $display("FAIL stall_resume[%0d] got %b/%0d exp %b/%0d", s, zout_valid, zout, ev[s], ez[s]); end
            mem_rd_addr = 8'h20 + 8'(s); #1;
            checks++; if (mem_rd_data !== em[s]) begin errors++;
                $display("FAIL stall_resume_mem[%0d] got %0d exp %0d", s, mem_rd_data, em[s]); end
        end
    endtask

    task automatic test_illegal();
        logic        ev[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] ez[8] = '{16'd61, 16'd61, 16'd8, 16'd8, 16'd13, 16'd13, 16'd8, 16'd8};
        logic        ee[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        mc[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0]  ma[8] = '{8'h0, 8'h0, 8'h0, 8'h40, 8'h23, 8'h41, 8'h0, 8'h42};
        logic [15:0] mv[8] = '{16'd0, 16'd0, 16'd0, 16'd8, 16'd61, 16'd13, 16'd0, 16'd8};
        for (int s = 0; s < 8; s++) begin
            case (s)
                0:       issue(1'b1, 4'd1, 4'd2, 4'd10, 4'd0, 8'h40);
                1:       issue(1'b1, 4'd1, 4'd2, 4'd10, 4'd13, 8'h23);
                2:       issue(1'b1, 4'd10, 4'd1, 4'd11, 4'd0, 8'h41);
                4:       issue(1'b1, 4'd10, 4'd0, 4'd12, 4'd3, 8'h42);
                default: issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
            endcase
            checks++; if (zout_valid !== ev[s] || zout !== ez[s] || err_illegal !== ee[s]) begin errors++;
                $display("FAIL illegal[%0d] got zv=%b z=%0d err=%b exp zv=%b z=%0d err=%b",
                         s, zout_valid, zout, err_illegal, ev[s], ez[s], ee[s]); end
            if (mc[s]) begin
                mem_rd_addr = ma[s]; #1;
                checks++; if (mem_rd_data !== mv[s]) begin errors++;
                    $display("FAIL illegal_mem[%0d] got %0d exp %0d", s, mem_rd_data, mv[s]); end
            end
        end
    endtask

    task automatic test_arith_bounds();
        logic [3:0]  f [10] = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd8, 4'd2, 4'd9, 4'd7, 4'd5, 4'd6};
        logic [3:0]  a [10] = '{4'd12, 4'd14, 4'd15, 4'd0, 4'd13, 4'd1, 4'd0, 4'd12, 4'd0, 4'd15};
        logic [3:0]  b [10] = '{4'd13, 4'd13, 4'd0, 4'd0, 4'd0, 4'd1, 4'd12, 4'd15, 4'd12, 4'd13};
        logic [15:0] ex[10] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h4000, 16'hFFFF,
                                16'h0000, 16'h0001, 16'h7FFF, 16'h8001, 16'h8001};
        dut.r_regbank[0]  <= 16'h8001;
        dut.r_regbank[1]  <= 16'h0100;
        dut.r_regbank[12] <= 16'hFFFF;
        dut.r_regbank[13] <= 16'h0001;
        dut.r_regbank[14] <= 16'h0000;
        dut.r_regbank[15] <= 16'h8000;
        for (int s = 0; s < 12; s++) begin
            if (s < 10) issue(1'b1, a[s], b[s], 4'(s + 2), f[s], 8'(8'h50 + s));
            else        issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
            if (s >= 2) begin
                checks++; if (zout_valid !== 1'b1 || zout !== ex[s-2]) begin errors++;
                    $display("FAIL arith[%0d] got %b/%h exp 1/%h", s-2, zout_valid, zout, ex[s-2]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        // r5 = 0x4000 and r8 = 0x0001 from the boundary vectors
        logic [15:0] ex[3] = '{16'h8000, 16'h7FFF, 16'h3FFF};
        for (int s = 0; s < 5; s++) begin
            case (s)
                0:       issue(1'b1, 4'd5, 4'd5, 4'd5, 4'd0, 8'h60);
                1:       issue(1'b1, 4'd5, 4'd8, 4'd5, 4'd1, 8'h61);
                2:       issue(1'b1, 4'd5, 4'd5, 4'd5, 4'd10, 8'h62);
                default: issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
            endcase
            if (s >= 2) begin
                checks++; if (zout_valid !== 1'b1 || zout !== ex[s-2]) begin errors++;
                    $display("FAIL b2b_self[%0d] got %b/%h exp 1/%h", s-2, zout_valid, zout, ex[s-2]); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] em[3] = '{16'd51, 16'd56, 16'd5};
        issue(1'b1, 4'd13, 4'd0, 4'd12, 4'd3, 8'h20);
        issue(1'b1, 4'd13, 4'd13, 4'd12, 4'd0, 8'h21);
        issue(1'b1, 4'd13, 4'd13, 4'd12, 4'd0, 8'h22);
        checks++; if (zout_valid !== 1'b1 || zout !== 16'd1) begin errors++;
            $display("FAIL midrst_pre got %b/%0d exp 1/1", zout_valid, zout); end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (zout !== 16'h0 || zout_valid !== 1'b0 || err_illegal !== 1'b0) begin errors++;
            $display("FAIL midrst_clear got %h/%b/%b exp 0000/0/0", zout, zout_valid, err_illegal); end
        step(); step();
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
        checks++; if (zout_valid !== 1'b0) begin errors++;
            $display("FAIL midrst_zv got %b exp 0", zout_valid); end
        for (int i = 0; i < 3; i++) begin
            mem_rd_addr = 8'h20 + 8'(i); #1;
            checks++; if (mem_rd_data !== em[i]) begin errors++;
                $display("FAIL midrst_mem[%0d] got %0d exp %0d", i, mem_rd_data, em[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_chain();
        test_stall();
        test_illegal();
        test_arith_bounds();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
